kmp_matcher: RTL and testbench
==============================

# kmp_matcher

Parametrised streaming Knuth-Morris-Pratt string matcher that replaces the fixed ROM-bound matcher.
- Pattern is written into an internal register file, its failure (prefix) table is built on chip, and a text stream is then consumed over a valid/ready handshake.
- Reports every match position and a saturating match count.
- Sits between the text source (ROM reader or UART front end) and the display/readout logic.

## Interface
Parameters:
- CHAR_W, 8: character width in bits
- PAT_MAX, 8: maximum pattern length (≥2)
- POS_W, 14: text position counter width
- CNT_W, 8: match counter width
- Derived: PL_W = $clog2(PAT_MAX+1), defined in kmp_pkg.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pat_we  in  1  pattern write strobe (honoured in IDLE only)
- pat_waddr  in  $clog2(PAT_MAX)  pattern write index
- pat_wdata  in  CHAR_W  pattern character
- pat_len  in  PL_W  pattern length, sampled on start
- start  in  1  begin build+search (honoured in IDLE only)
- txt_valid  in  1  text character valid
- txt_char  in  CHAR_W  text character
- txt_last  in  1  marks final text character
- txt_ready  out  1  text character consumed this cycle
- match_valid  out  1  one-cycle pulse per match
- match_pos  out  POS_W  0-based text index of the match's last character
- count  out  CNT_W  matches found, saturating
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of search
- cfg_err  out  1  sticky: last start had illegal pat_len

## Operation
States:
- IDLE: start with 2 ≤ pat_len ≤ PAT_MAX → BUILD.
  - Also clears count, pos, q, cfg_err.
  - Captures len.
- IDLE, illegal start: pat_len < 2 or pat_len > PAT_MAX → DONE, with cfg_err=1 and count=0.
- BUILD: i=1, k=0, fail[0]=0. One step per cycle:
  - pat[i]==pat[k]: fail[i]=k+1, k++, i++.
  - Else if k>0: k=fail[k-1].
  - Else: fail[i]=0, i++.
  - i==len → SEARCH.
- SEARCH: q = matched prefix length. In each cycle with txt_valid, compare txt_char with pat[q]:
  - Equal: consume, q++. If q+1==len: match_valid=1 next cycle, match_pos=pos, count++ (saturating), q = next-state per Configuration.
  - Unequal, q>0: do not consume (txt_ready=0), q=fail[q-1].
  - Unequal, q==0: consume, q stays 0.
  - pos increments on every consume and wraps at 2^POS_W.
  - Consuming with txt_last=1 → DONE. A match on the last character is still reported.
- DONE: done=1 for one cycle → IDLE. count and cfg_err hold until the next start.

Handshake and ignored inputs:
- txt_ready = (state==SEARCH) && txt_valid && (txt_char==pat[q] || q==0). It is combinational from txt_char.
- The source must hold txt_valid/txt_char stable until they are consumed, and must not make txt_valid depend on txt_ready.
- start in a non-IDLE state is ignored.
- pat_we in a non-IDLE state is ignored.

## Timing
- Reset values: state=IDLE; txt_ready, match_valid, done, busy, cfg_err all 0; count=0; match_pos=0; fail table, q, pos all 0. The pattern register file is not reset.
- start → SEARCH takes 1 + B cycles, with len-1 ≤ B ≤ 2(len-1).
- match_valid, match_pos and count are registered: they update on the edge following the consuming cycle.
- Throughput: one character per cycle, except one stall cycle per failure-link step.
- rst asserted mid-BUILD/SEARCH: immediate return to IDLE, with all outputs at reset values.

## Configuration
- KMP_OVERLAP_EN defined: after a match, q = fail[len-1]. Overlapping matches are counted.
- KMP_OVERLAP_EN undefined: after a match, q = 0. Only non-overlapping matches are counted.

## Structure
- kmp_pkg contains:
  - state enum (IDLE, BUILD, SEARCH, DONE)
  - default widths
  - the PL_W helper
- Sub-module kmp_prefix_builder:
  - Owns the BUILD loop and the fail table.
  - Exposes a start/done pulse pair and a read port fail_rd(idx).
- kmp_matcher holds the pattern file, the search datapath and the top FSM.

## Test plan
- Pattern "ABAB", len 4 → BUILD lasts 3 cycles, fail = [0,0,1,2].
- With KMP_OVERLAP_EN, text "ABABAB" (last on final B) → matches at pos 3 and 5, count=2, one done pulse.
- Without KMP_OVERLAP_EN, same text → single match at pos 3, count=1.
- Pattern "AAB", text "AAAB" → exactly one stall cycle (txt_ready=0 on the third A), then match at pos 3.
- start with pat_len=1, then with pat_len=9 (PAT_MAX=8) → done next cycle, cfg_err=1, count=0, no match_valid.
- rst asserted mid-SEARCH after 1 match → count=0 and busy=0 immediately; a fresh start reruns cleanly.
- Repeated "A" stream (CNT_W=2) against pattern "AA" with KMP_OVERLAP_EN → count saturates at 3.
- start and pat_we asserted during SEARCH → no effect.

Source files
------------

// File: rtl/kmp_pkg.sv
// kmp_pkg: shared state encoding, default widths and the pattern-length width helper.
package kmp_pkg;
    typedef enum logic [1:0] {IDLE, BUILD, SEARCH, DONE} state_t;
    localparam int CHAR_W_D  = 8;
    localparam int PAT_MAX_D = 8;
    localparam int POS_W_D   = 14;
    localparam int CNT_W_D   = 8;
    function automatic int pl_w(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction
endpackage

// File: rtl/kmp_prefix_builder.sv
// kmp_prefix_builder: builds the KMP failure table one step per cycle and serves reads from it.
module kmp_prefix_builder
    import kmp_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_D,
    parameter int PAT_MAX = PAT_MAX_D,
    localparam int PL_W   = pl_w(PAT_MAX),
    localparam int AW     = $clog2(PAT_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PL_W-1:0]   len,
    output logic [AW-1:0]     i_idx,
    output logic [AW-1:0]     k_idx,
    input  logic [CHAR_W-1:0] ch_i,
    input  logic [CHAR_W-1:0] ch_k,
    input  logic [AW-1:0]     fail_idx,
    output logic [AW-1:0]     fail_rd,
    output logic              done
);
    logic            running;
    logic [PL_W-1:0] i;
    logic [AW-1:0]   k;
    logic [AW-1:0]   fail [PAT_MAX];
    logic            eq;
    logic            adv;

    assign i_idx   = AW'(i);
    assign k_idx   = k;
    assign eq      = ch_i == ch_k;
    assign adv     = running && (eq || k == '0);
    assign done    = adv && (i + PL_W'(1) == len);
    assign fail_rd = fail[fail_idx];

    // i advances only when an entry is written; a failure-link step just rewinds k
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            i       <= '0;
            k       <= '0;
            for (int j = 0; j < PAT_MAX; j++) fail[j] <= '0;
        end else if (start) begin
            running <= 1'b1;
            i       <= PL_W'(1);
            k       <= '0;
            fail[0] <= '0;
        end else if (running) begin
            if (adv) begin
                fail[i_idx] <= eq ? k + AW'(1) : '0;
                i           <= i + PL_W'(1);
            end
            if (eq) k <= k + AW'(1);
            else if (k != '0) k <= fail[k - AW'(1)];
            if (done) running <= 1'b0;
        end
    end
endmodule

// File: rtl/kmp_matcher.sv
// kmp_matcher: streaming KMP matcher with on-chip failure-table build and valid/ready text input.
// Define KMP_OVERLAP_EN to resume from fail[len-1] after a match so overlapping matches count.
module kmp_matcher
    import kmp_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_D,
    parameter int PAT_MAX = PAT_MAX_D,
    parameter int POS_W   = POS_W_D,
    parameter int CNT_W   = CNT_W_D,
    localparam int PL_W   = pl_w(PAT_MAX),
    localparam int AW     = $clog2(PAT_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pat_we,
    input  logic [AW-1:0]     pat_waddr,
    input  logic [CHAR_W-1:0] pat_wdata,
    input  logic [PL_W-1:0]   pat_len,
    input  logic              start,
    input  logic              txt_valid,
    input  logic [CHAR_W-1:0] txt_char,
    input  logic              txt_last,
    output logic              txt_ready,
    output logic              match_valid,
    output logic [POS_W-1:0]  match_pos,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    logic [CHAR_W-1:0] pat [PAT_MAX];
    state_t            state;
    logic [PL_W-1:0]   len;
    logic [AW-1:0]     q, bi, bk, fail_idx, fail_rd, q_wrap;
    logic [POS_W-1:0]  pos;
    logic              legal, bld_start, bld_done, eq, hit;

    assign legal     = pat_len >= PL_W'(2) && pat_len <= PL_W'(PAT_MAX);
    assign bld_start = state == IDLE && start && legal;
    assign eq        = txt_char == pat[q];
    assign hit       = eq && (PL_W'(q) + PL_W'(1) == len);
    assign txt_ready = state == SEARCH && txt_valid && (eq || q == '0);
    assign busy      = state != IDLE;

    // a single fail-table read port serves both the mismatch rewind and the post-match resume
`ifdef KMP_OVERLAP_EN
    assign fail_idx = hit ? q : q - AW'(1);
    assign q_wrap   = fail_rd;
`else
    assign fail_idx = q - AW'(1);
    assign q_wrap   = '0;
`endif

    kmp_prefix_builder #(.CHAR_W(CHAR_W), .PAT_MAX(PAT_MAX)) u_builder (
        .clk      (clk),
        .rst      (rst),
        .start    (bld_start),
        .len      (pat_len),
        .i_idx    (bi),
        .k_idx    (bk),
        .ch_i     (pat[bi]),
        .ch_k     (pat[bk]),
        .fail_idx (fail_idx),
        .fail_rd  (fail_rd),
        .done     (bld_done)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && pat_we) pat[pat_waddr] <= pat_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            q           <= '0;
            pos         <= '0;
            count       <= '0;
            match_valid <= 1'b0;
            match_pos   <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    count   <= '0;
                    pos     <= '0;
                    q       <= '0;
                    len     <= pat_len;
                    cfg_err <= !legal;
                    done    <= !legal;
                    state   <= legal ? BUILD : DONE;
                end
                BUILD: if (bld_done) state <= SEARCH;
                SEARCH: if (txt_ready) begin
                    pos <= pos + POS_W'(1);
                    if (eq) q <= hit ? q_wrap : q + AW'(1);
                    if (hit) begin
                        match_valid <= 1'b1;
                        match_pos   <= pos;
                        count       <= count == '1 ? count : count + CNT_W'(1);
                    end
                    if (txt_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end else if (txt_valid) q <= fail_rd;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kmp_matcher.sv
// tb_kmp_matcher: directed and randomized checks of kmp_matcher against a brute-force substring model.
module tb_kmp_matcher;
    localparam int CW = 8, PM = 8, PW = 14, CN = 4;
    localparam int SAT = (1 << CN) - 1;
`ifdef KMP_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          pat_we = 1'b0, start = 1'b0, txt_valid = 1'b0, txt_last = 1'b0;
    logic [2:0]    pat_waddr = '0;
    logic [CW-1:0] pat_wdata = '0, txt_char = '0;
    logic [3:0]    pat_len = '0;
    logic          txt_ready, match_valid, busy, done, cfg_err;
    logic [PW-1:0] match_pos;
    logic [CN-1:0] count;

    kmp_matcher #(.CHAR_W(CW), .PAT_MAX(PM), .POS_W(PW), .CNT_W(CN)) dut (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
        .pat_len(pat_len), .start(start), .txt_valid(txt_valid), .txt_char(txt_char),
        .txt_last(txt_last), .txt_ready(txt_ready), .match_valid(match_valid),
        .match_pos(match_pos), .count(count), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int            n_tests = 0, n_fail = 0;
    int            got_q[$];
    int            done_cnt = 0;
    int            exp_q[$];
    logic [CW-1:0] pat_a [PM];
    logic [CW-1:0] txt_a [64];

    always @(negedge clk) begin
        if (match_valid) got_q.push_back(int'(match_pos));
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // every window equal to the pattern is a match; non-overlap mode keeps only windows past the previous match
    function automatic void model(input int len, input int n);
        int  last = -1;
        bit  m;
        exp_q.delete();
        for (int p = len - 1; p < n; p++) begin
            m = 1'b1;
            for (int j = 0; j < len; j++) if (txt_a[p - len + 1 + j] != pat_a[j]) m = 1'b0;
            if (m && (OV || p - len + 1 > last)) begin
                exp_q.push_back(p);
                last = p;
            end
        end
    endfunction

    task automatic set_str(input string p, input string t);
        for (int j = 0; j < p.len(); j++) pat_a[j] = p[j];
        for (int j = 0; j < t.len(); j++) txt_a[j] = t[j];
    endtask

    task automatic run_test(input string tag, input int len, input int n, input bit inj,
                            input bit rst_mid, output int lat, output int stalls);
        int b0, d0, idx, cyc, nexp;
        bit rdy_seen;
        for (int j = 0; j < len; j++) begin
            pat_we = 1'b1; pat_waddr = 3'(j); pat_wdata = pat_a[j];
            @(posedge clk); #1;
        end
        pat_we = 1'b0;
        b0 = got_q.size(); d0 = done_cnt;
        start = 1'b1; pat_len = 4'(len);
        txt_valid = 1'b1; txt_char = txt_a[0]; txt_last = n == 1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; stalls = 0; idx = 0; cyc = 0; rdy_seen = 1'b0;
        while (idx < n && cyc < 400 && !(rst_mid && got_q.size() > b0)) begin
            @(negedge clk);
            if (txt_ready) begin rdy_seen = 1'b1; idx++; end
            else if (rdy_seen) stalls++;
            else lat++;
            if (inj && rdy_seen) begin
                start = 1'b1; pat_len = 4'd3; pat_we = 1'b1; pat_waddr = 3'd0; pat_wdata = 8'h5A;
            end
            @(posedge clk); #1;
            start = 1'b0; pat_we = 1'b0; cyc++;
            if (idx < n) begin txt_char = txt_a[idx]; txt_last = idx == n - 1; end
            else begin txt_valid = 1'b0; txt_last = 1'b0; end
        end
        if (rst_mid) begin
            check({tag, " pre-rst count"}, int'(count), 1);
            #2 rst = 1'b1;
            #1;
            check({tag, " rst count"}, int'(count), 0);
            check({tag, " rst busy"}, int'(busy), 0);
            check({tag, " rst txt_ready"}, int'(txt_ready), 0);
            check({tag, " rst match_valid"}, int'(match_valid), 0);
            txt_valid = 1'b0; txt_last = 1'b0;
            @(posedge clk); #1 rst = 1'b0;
            return;
        end
        check({tag, " consumed"}, idx, n);
        @(negedge clk);
        check({tag, " done pulse"}, int'(done), 1);
        @(negedge clk);
        model(len, n);
        nexp = exp_q.size() > SAT ? SAT : exp_q.size();
        check({tag, " done low"}, int'(done), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done count"}, done_cnt - d0, 1);
        check({tag, " cfg_err"}, int'(cfg_err), 0);
        check({tag, " count"}, int'(count), nexp);
        check({tag, " matches"}, got_q.size() - b0, exp_q.size());
        for (int j = 0; j < exp_q.size() && b0 + j < got_q.size(); j++)
            check({tag, " match_pos"}, got_q[b0 + j], exp_q[j]);
    endtask

    task automatic illegal(input int l);
        int b0 = got_q.size();
        start = 1'b1; pat_len = 4'(l);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("illegal done", int'(done), 1);
        check("illegal cfg_err", int'(cfg_err), 1);
        check("illegal count", int'(count), 0);
        check("illegal busy", int'(busy), 1);
        @(negedge clk);
        check("illegal done low", int'(done), 0);
        check("illegal idle", int'(busy), 0);
        check("illegal cfg_err sticky", int'(cfg_err), 1);
        check("illegal no match", got_q.size() - b0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, st, len, n, off;
        txt_valid = 1'b1;
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset count", int'(count), 0);
        check("reset match_valid", int'(match_valid), 0);
        check("reset match_pos", int'(match_pos), 0);
        check("reset cfg_err", int'(cfg_err), 0);
        check("reset txt_ready", int'(txt_ready), 0);
        txt_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        set_str("ABAB", "ABABAB");
        run_test("abab", 4, 6, 1'b1, 1'b0, lat, st);
        check("abab build latency", lat, 4);
        check("abab stalls", st, 0);

        set_str("AAB", "AAAB");
        run_test("aab", 3, 4, 1'b0, 1'b0, lat, st);
        check("aab build latency", lat, 4);
        check("aab stalls", st, 1);

        illegal(1);
        illegal(9);
        illegal(0);

        set_str("AB", "ABAAAAAAAA");
        run_test("rstmid", 2, 10, 1'b0, 1'b1, lat, st);
        set_str("ABAB", "ABABAB");
        run_test("rerun", 4, 6, 1'b0, 1'b0, lat, st);

        set_str("AA", "");
        for (int j = 0; j < 40; j++) txt_a[j] = "A";
        run_test("saturate", 2, 40, 1'b0, 1'b0, lat, st);

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(2, PM);
            n = $urandom_range(1, 60);
            for (int j = 0; j < len; j++) pat_a[j] = 8'(8'h41 + $urandom_range(0, 1));
            for (int j = 0; j < n; j++) txt_a[j] = 8'(8'h41 + $urandom_range(0, 1));
            if (n >= len && $urandom_range(0, 1) == 1) begin
                off = $urandom_range(0, n - len);
                for (int j = 0; j < len; j++) txt_a[off + j] = pat_a[j];
            end
            run_test("random", len, n, 1'b0, 1'b0, lat, st);
            check("random build latency", int'(lat - 1 >= len - 1 && lat - 1 <= 2 * (len - 1)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
